// File: rtl/ascii_pkg.sv
// rtl/ascii_pkg.sv - shared tile geometry defaults, pixel type and tile buffer states
// Shared with the ASCII fill stage so both ends agree on tile shape and pixel format.
// No ports.
package ascii_pkg;

    localparam int DEF_TILE_WIDTH  = 8;
    localparam int DEF_TILE_HEIGHT = 8;
    localparam int DEF_COLORS      = 3;
    localparam int DEF_COLOR_DEPTH = 8;

    typedef logic [DEF_COLORS*DEF_COLOR_DEPTH-1:0] pixel_t;

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } tile_state_e;

endpackage

// File: rtl/ascii_tile_buffer_if.sv
// rtl/ascii_tile_buffer_if.sv - raster pixel input and tile output handshakes of the tile buffer
// Pixel side : in_pixel, in_valid, in_sof, in_eol (to buffer), in_ready (from buffer)
// Tile side  : tile_data[x][y], tile_valid, tile_col, tile_row (from buffer), tile_ready (to buffer)
// Modports   : slave = the tile buffer, master = the pixel source / tile consumer
interface ascii_tile_buffer_if #(
    parameter int IMG_WIDTH   = 64,
    parameter int TILE_WIDTH  = ascii_pkg::DEF_TILE_WIDTH,
    parameter int TILE_HEIGHT = ascii_pkg::DEF_TILE_HEIGHT,
    parameter int DATA_WIDTH  = ascii_pkg::DEF_COLORS * ascii_pkg::DEF_COLOR_DEPTH
);
    localparam int N_TILES = IMG_WIDTH / TILE_WIDTH;
    localparam int COL_W   = (N_TILES > 1) ? $clog2(N_TILES) : 1;

    logic [DATA_WIDTH-1:0] in_pixel;
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_sof;
    logic                  in_eol;

    logic [TILE_WIDTH-1:0][TILE_HEIGHT-1:0][DATA_WIDTH-1:0] tile_data;
    logic                  tile_valid;
    logic                  tile_ready;
    logic [COL_W-1:0]      tile_col;
    logic [15:0]           tile_row;

    modport slave (
        input  in_pixel, in_valid, in_sof, in_eol, tile_ready,
        output in_ready, tile_data, tile_valid, tile_col, tile_row
    );

    modport master (
        output in_pixel, in_valid, in_sof, in_eol, tile_ready,
        input  in_ready, tile_data, tile_valid, tile_col, tile_row
    );

endinterface

// File: rtl/ascii_band_store.sv
// rtl/ascii_band_store.sv - one band of TILE_HEIGHT image lines with a tile-wide parallel read port
// i_wr_en/i_wr_row/i_wr_col/i_wr_data : single-pixel write port
// i_rd_tile                           : tile column to present
// o_rd_data[x][y]                     : band[y][i_rd_tile*TILE_WIDTH + x], combinational
module ascii_band_store #(
    parameter int IMG_WIDTH   = 64,
    parameter int TILE_WIDTH  = 8,
    parameter int TILE_HEIGHT = 8,
    parameter int DATA_WIDTH  = 24,
    parameter int ROW_W       = 3,
    parameter int X_W         = 6,
    parameter int COL_W       = 3
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ROW_W-1:0]      i_wr_row,
    input  logic [X_W-1:0]        i_wr_col,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [COL_W-1:0]      i_rd_tile,
    output logic [TILE_WIDTH-1:0][TILE_HEIGHT-1:0][DATA_WIDTH-1:0] o_rd_data
);
    import ascii_pkg::*;

    // Contents are never reset: a band is always fully rewritten before it is read.
    logic [DATA_WIDTH-1:0] r_band [TILE_HEIGHT][IMG_WIDTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_band[i_wr_row][i_wr_col] <= i_wr_data;
        end
    end

    for (genvar gx = 0; gx < TILE_WIDTH; gx++) begin : g_x
        logic [X_W-1:0] w_col;
        assign w_col = X_W'(int'(i_rd_tile) * TILE_WIDTH + gx);
        for (genvar gy = 0; gy < TILE_HEIGHT; gy++) begin : g_y
            assign o_rd_data[gx][gy] = r_band[gy][w_col];
        end
    end

endmodule

// File: rtl/ascii_tile_buffer.sv
// rtl/ascii_tile_buffer.sv - collects a raster band of TILE_HEIGHT lines and emits it as tiles
// clk, rst : clock, synchronous active-high reset
// bus      : ascii_tile_buffer_if.slave (pixel input handshake, tile output handshake)
// err      : sticky line-length error, only with ASCII_TILE_LINE_CHECK_EN defined, else 0
module ascii_tile_buffer #(
    parameter int IMG_WIDTH   = 64,
    parameter int TILE_WIDTH  = ascii_pkg::DEF_TILE_WIDTH,
    parameter int TILE_HEIGHT = ascii_pkg::DEF_TILE_HEIGHT,
    parameter int COLORS      = ascii_pkg::DEF_COLORS,
    parameter int COLOR_DEPTH = ascii_pkg::DEF_COLOR_DEPTH,
    parameter int DATA_WIDTH  = COLORS * COLOR_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    ascii_tile_buffer_if.slave  bus,
    output logic                err
);
    import ascii_pkg::*;

    localparam int N_TILES = IMG_WIDTH / TILE_WIDTH;
    localparam int COL_W   = (N_TILES > 1) ? $clog2(N_TILES) : 1;
    localparam int ROW_W   = (TILE_HEIGHT > 1) ? $clog2(TILE_HEIGHT) : 1;
    localparam int X_W     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    localparam logic [0:0] FILL  = ST_FILL;
    localparam logic [0:0] DRAIN = ST_DRAIN;

    logic [0:0]       r_state;
    logic [ROW_W-1:0] r_row;
    logic [X_W-1:0]   r_col;
    logic [COL_W-1:0] r_tile_col;
    logic [15:0]      r_tile_row;

    logic             w_in_ready;
    logic             w_tile_valid;
    logic             w_accept;
    logic [ROW_W-1:0] w_wr_row;
    logic [X_W-1:0]   w_wr_col;
    logic             w_col_last;
    logic             w_row_last;
    logic             w_eol_early;
    logic             w_line_end;
    logic             w_tile_last;

    // Both handshakes are held off during the reset cycle itself.
    assign w_in_ready   = !rst && (r_state == FILL);
    assign w_tile_valid = !rst && (r_state == DRAIN);
    assign w_accept     = bus.in_valid && w_in_ready;

    // A start-of-frame pixel restarts the band at the origin whatever the current position.
    assign w_wr_row    = bus.in_sof ? '0 : r_row;
    assign w_wr_col    = bus.in_sof ? '0 : r_col;
    assign w_col_last  = (w_wr_col == X_W'(IMG_WIDTH - 1));
    assign w_row_last  = (w_wr_row == ROW_W'(TILE_HEIGHT - 1));
    assign w_tile_last = (r_tile_col == COL_W'(N_TILES - 1));

`ifdef ASCII_TILE_LINE_CHECK_EN
    // A short line is closed early so the following line still starts at column 0.
    assign w_eol_early = bus.in_eol && !w_col_last;

    logic r_err;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept && (w_eol_early || (w_col_last && !bus.in_eol))) begin
            r_err <= 1'b1;
        end
    end
    assign err = r_err;
`else
    logic w_unused_eol;
    assign w_unused_eol = bus.in_eol;
    assign w_eol_early  = 1'b0;
    assign err          = 1'b0;
`endif

    assign w_line_end = w_col_last || w_eol_early;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FILL;
            r_row      <= '0;
            r_col      <= '0;
            r_tile_col <= '0;
            r_tile_row <= '0;
        end else if (r_state == FILL) begin
            if (w_accept) begin
                if (bus.in_sof) begin
                    r_tile_row <= '0;
                end
                if (w_line_end) begin
                    r_col <= '0;
                    if (w_row_last) begin
                        r_row      <= '0;
                        r_tile_col <= '0;
                        r_state    <= DRAIN;
                    end else begin
                        r_row <= w_wr_row + 1'b1;
                    end
                end else begin
                    r_col <= w_wr_col + 1'b1;
                    r_row <= w_wr_row;
                end
            end
        end else if (bus.tile_ready) begin
            if (w_tile_last) begin
                r_tile_col <= '0;
                r_tile_row <= r_tile_row + 1'b1;
                r_state    <= FILL;
            end else begin
                r_tile_col <= r_tile_col + 1'b1;
            end
        end
    end

    ascii_band_store #(
        .IMG_WIDTH  (IMG_WIDTH),
        .TILE_WIDTH (TILE_WIDTH),
        .TILE_HEIGHT(TILE_HEIGHT),
        .DATA_WIDTH (DATA_WIDTH),
        .ROW_W      (ROW_W),
        .X_W        (X_W),
        .COL_W      (COL_W)
    ) u_band_store (
        .clk      (clk),
        .i_wr_en  (w_accept),
        .i_wr_row (w_wr_row),
        .i_wr_col (w_wr_col),
        .i_wr_data(bus.in_pixel),
        .i_rd_tile(r_tile_col),
        .o_rd_data(bus.tile_data)
    );

    assign bus.in_ready   = w_in_ready;
    assign bus.tile_valid = w_tile_valid;
    assign bus.tile_col   = r_tile_col;
    assign bus.tile_row   = r_tile_row;

endmodule

// File: tb/tb_ascii_tile_buffer.sv
// tb/tb_ascii_tile_buffer.sv - self-checking bench for ascii_tile_buffer (16-pixel lines, 8x8 tiles)
module tb_ascii_tile_buffer;
    import ascii_pkg::*;

    localparam int IW   = 16;
    localparam int TW   = 8;
    localparam int TH   = 8;
    localparam int DW   = 24;
    localparam int NT   = IW / TW;
    localparam int BAND = IW * TH;
`ifdef ASCII_TILE_LINE_CHECK_EN
    localparam bit EXP_ERR = 1'b1;
`else
    localparam bit EXP_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err;

    ascii_tile_buffer_if #(.IMG_WIDTH(IW), .TILE_WIDTH(TW), .TILE_HEIGHT(TH), .DATA_WIDTH(DW)) tb_if ();

    ascii_tile_buffer #(.IMG_WIDTH(IW), .TILE_WIDTH(TW), .TILE_HEIGHT(TH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(tb_if.slave),
        .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: the band as the image sees it, the raster position inside
    // the band as a plain pixel count, and the expected tile row number.
    pixel_t band [TH][IW];
    int     k;
    int     exp_row;

    function automatic pixel_t rc_pix(input int i);
        return {8'h00, 8'(i / IW), 8'(i % IW)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_tile(input string tag, input int tc);
        int bad = 0;
        int bx = 0, by = 0;
        pixel_t o = '0, e = '0;
        for (int x = 0; x < TW; x++) begin
            for (int y = 0; y < TH; y++) begin
                if (tb_if.tile_data[x][y] !== band[y][tc*TW + x]) begin
                    if (bad == 0) begin
                        bx = x; by = y;
                        o = tb_if.tile_data[x][y];
                        e = band[y][tc*TW + x];
                    end
                    bad++;
                end
            end
        end
        checks++;
        assert (bad == 0) else begin
            errors++;
            $error("FAIL %s tile %0d [%0d][%0d] observed=%0h expected=%0h (%0d wrong)", tag, tc, bx, by, o, e, bad);
        end
    endtask

    // Moves to the next falling edge and returns all inputs to idle.
    task automatic step();
        @(negedge clk);
        tb_if.in_valid   = 1'b0;
        tb_if.in_sof     = 1'b0;
        tb_if.in_eol     = 1'b0;
        tb_if.in_pixel   = '0;
        tb_if.tile_ready = 1'b0;
    endtask

    task automatic push_px(input pixel_t data, input bit sof, input bit bad_eol, input int gap);
        int col;
        for (int g = 0; g < gap; g++) begin
            step(); #1;
        end
        if (sof) begin
            k = 0;
            exp_row = 0;
        end
        col = k % IW;
        step();
        tb_if.in_valid = 1'b1;
        tb_if.in_pixel = data;
        tb_if.in_sof   = sof;
        tb_if.in_eol   = bad_eol || (col == IW - 1);
        #1;
        chk("in_ready_fill", tb_if.in_ready, 1);
        band[k / IW][col] = data;
`ifdef ASCII_TILE_LINE_CHECK_EN
        if (bad_eol && col != IW - 1) k = (k / IW + 1) * IW;
        else k++;
`else
        k++;
`endif
        if (k >= BAND) k = 0;
    endtask

    task automatic fill_rand(input int n, input int gapmax);
        for (int i = 0; i < n; i++) push_px(pixel_t'($urandom), 1'b0, 1'b0, $urandom_range(0, gapmax));
    endtask

    task automatic recv_tiles(input bit rnd_ready);
        for (int tc = 0; tc < NT; tc++) begin
            bit done = 1'b0;
            for (int cyc = 0; cyc < 100 && !done; cyc++) begin
                step();
                tb_if.tile_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                #1;
                if (tb_if.tile_valid) begin
                    chk("in_ready_drain", tb_if.in_ready, 0);
                    chk("tile_col", tb_if.tile_col, tc);
                    chk("tile_row", tb_if.tile_row, exp_row);
                    chk_tile("tile_data", tc);
                    if (tb_if.tile_ready) done = 1'b1;
                end
            end
            checks++;
            assert (done) else begin
                errors++;
                $error("FAIL tile_timeout observed=no tile expected=tile %0d", tc);
            end
        end
        exp_row = (exp_row + 1) & 16'hffff;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tb_if.in_valid   = 1'b0;
        tb_if.in_sof     = 1'b0;
        tb_if.in_eol     = 1'b0;
        tb_if.in_pixel   = '0;
        tb_if.tile_ready = 1'b0;
        k = 0;
        exp_row = 0;

        // Reset values.
        step(); rst = 1'b1; #1;
        chk("rst_in_ready", tb_if.in_ready, 0);
        chk("rst_tile_valid", tb_if.tile_valid, 0);
        chk("rst_err", err, 0);
        step(); rst = 1'b0; #1;
        chk("rst_tile_col", tb_if.tile_col, 0);
        chk("rst_tile_row", tb_if.tile_row, 0);
        chk("rst_idle_valid", tb_if.tile_valid, 0);
        chk("rst_idle_ready", tb_if.in_ready, 1);

        // Directed band of {row,col} pixels, tiles taken back to back.
        for (int i = 0; i < BAND; i++) push_px(rc_pix(i), i == 0, 1'b0, 0);
        step(); tb_if.tile_ready = 1'b1; #1;
        chk("d_valid0", tb_if.tile_valid, 1);
        chk("d_col0", tb_if.tile_col, 0);
        chk("d_px35_t0", tb_if.tile_data[3][5], 24'h000503);
        chk("d_ready0", tb_if.in_ready, 0);
        step(); tb_if.tile_ready = 1'b1; #1;
        chk("d_valid1", tb_if.tile_valid, 1);
        chk("d_col1", tb_if.tile_col, 1);
        chk("d_px35_t1", tb_if.tile_data[3][5], 24'h00050B);
        chk("d_ready1", tb_if.in_ready, 0);
        step(); #1;
        chk("d_done_valid", tb_if.tile_valid, 0);
        chk("d_done_ready", tb_if.in_ready, 1);
        chk("d_done_row", tb_if.tile_row, 1);
        exp_row = 1;

        // Back-pressure: tile must hold still while tile_ready is low.
        fill_rand(BAND, 0);
        for (int i = 0; i < 5; i++) begin
            step(); #1;
            chk("hold_valid", tb_if.tile_valid, 1);
            chk("hold_col", tb_if.tile_col, 0);
            chk_tile("hold_data", 0);
        end
        recv_tiles(1'b0);

        // Random data, random input gaps, random tile back-pressure.
        for (int b = 0; b < 3; b++) begin
            fill_rand(BAND, 2);
            recv_tiles(1'b1);
        end

        // Start of frame in the middle of a band restarts it and tile_row.
        fill_rand(40, 0);
        push_px(pixel_t'($urandom), 1'b1, 1'b0, 0);
        fill_rand(BAND - 1, 1);
        recv_tiles(1'b0);

        // Reset while the second tile is on offer abandons the band.
        fill_rand(BAND, 0);
        step(); tb_if.tile_ready = 1'b1; #1;
        chk("r_valid0", tb_if.tile_valid, 1);
        chk("r_col0", tb_if.tile_col, 0);
        step(); rst = 1'b1; #1;
        chk("r_col1", tb_if.tile_col, 1);
        chk("r_rst_ready", tb_if.in_ready, 0);
        step(); rst = 1'b0; #1;
        chk("r_after_valid", tb_if.tile_valid, 0);
        chk("r_after_ready", tb_if.in_ready, 1);
        chk("r_after_col", tb_if.tile_col, 0);
        chk("r_after_row", tb_if.tile_row, 0);
        k = 0;
        exp_row = 0;
        fill_rand(BAND - 1, 0);
        step(); #1;
        chk("r_partial_valid", tb_if.tile_valid, 0);
        fill_rand(1, 0);
        recv_tiles(1'b1);
        chk("err_clean", err, 0);

        // Early end of line at column 9.
        fill_rand(9, 0);
        push_px(pixel_t'($urandom), 1'b0, 1'b1, 0);
        step(); #1;
        chk("eol_err", err, 32'(EXP_ERR));
        do push_px(pixel_t'($urandom), 1'b0, 1'b0, 0); while (k != 0);
        recv_tiles(1'b0);
        chk("eol_err_sticky", err, 32'(EXP_ERR));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ascii_tile_buffer.md
ASCII_TILE_BUFFER -- requirements
Module: ascii_tile_buffer

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 64, meaning pixels per image line; it must be a multiple of TILE_WIDTH.
REQ-002 SHALL have parameter TILE_WIDTH, default 8, meaning tile columns.
REQ-003 SHALL have parameter TILE_HEIGHT, default 8, meaning tile rows (band height).
REQ-004 SHALL have parameters COLORS 3, COLOR_DEPTH 8, and DATA_WIDTH = COLORS*COLOR_DEPTH, meaning RGB pixel format.
REQ-005 SHALL have port clk, input, 1 bit, the clock.
REQ-006 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-007 SHALL have port in_pixel, input, DATA_WIDTH bits: raster pixel.
REQ-008 SHALL have ports in_valid (input, 1) and in_ready (output, 1): pixel handshake.
REQ-009 SHALL have port in_sof, input, 1 bit: first pixel of frame, qualified by in_valid.
REQ-010 SHALL have port in_eol, input, 1 bit: last pixel of line, qualified by in_valid.
REQ-011 SHALL have port tile_data, output, DATA_WIDTH x [TILE_WIDTH][TILE_HEIGHT]: tile, indexed [x][y].
REQ-012 SHALL have ports tile_valid (output, 1) and tile_ready (input, 1): tile handshake; tile_ready is tied high when driving the ASCII fill stage's enable.
REQ-013 SHALL have ports tile_col (output, $clog2(IMG_WIDTH/TILE_WIDTH)) and tile_row (output, 16): tile coordinates.
REQ-014 SHALL have port err, output, 1 bit: sticky line-length error.

Function
REQ-015 SHALL implement two states, FILL and DRAIN; in_ready=1 only in FILL, and tile_valid=1 only in DRAIN.
REQ-016 In FILL, a pixel SHALL be accepted when in_valid&&in_ready and written to band[row][col]; col then increments and wraps at IMG_WIDTH-1 to 0 with row+1.
REQ-017 An accepted pixel with in_sof SHALL be written to (row 0, col 0), and tile_row SHALL be cleared to 0, regardless of the current position.
REQ-018 Accepting the pixel at col=IMG_WIDTH-1, row=TILE_HEIGHT-1 SHALL move to DRAIN on the next cycle with row, col and tile_col=0.
REQ-019 In DRAIN, tile_data[x][y] SHALL equal band[y][tile_col*TILE_WIDTH+x], with latency of 1 cycle from the last band pixel to the first tile_valid.
REQ-020 tile_data, tile_col and tile_row SHALL remain stable while tile_valid&&!tile_ready.
REQ-021 On tile_valid&&tile_ready, tile_col SHALL increment; at the last tile (IMG_WIDTH/TILE_WIDTH-1), the block SHALL return to FILL, increment tile_row (wrapping at 2^16), and reset tile_col to 0.
REQ-022 The band SHALL be fully overwritten before the next DRAIN; no pixel SHALL be dropped or duplicated.

Reset
REQ-023 On rst, state SHALL be FILL, row=col=tile_col=tile_row=0, tile_valid=0, in_ready=0 during the reset cycle, and err=0; band contents are don't-care.
REQ-024 Reset asserted mid-FILL or mid-DRAIN SHALL abandon the partial band; no tile_valid SHALL occur until a full new band is filled.

Configuration
REQ-025 With macro ASCII_TILE_LINE_CHECK_EN defined, err SHALL set when in_eol is accepted at col!=IMG_WIDTH-1 (col is then forced to 0 and row+1) or when col=IMG_WIDTH-1 is accepted without in_eol; err SHALL clear only on rst.
REQ-026 Without ASCII_TILE_LINE_CHECK_EN, in_eol SHALL be ignored and err SHALL be tied to 0.

Structure
REQ-027 Package ascii_pkg SHALL hold TILE_WIDTH, TILE_HEIGHT, COLORS, COLOR_DEPTH defaults, typedef pixel_t, and the FILL/DRAIN state enum; the package is shared with the ASCII fill stage.
REQ-028 Band storage SHALL be a single sub-module, ascii_band_store, with a write port and a TILE_WIDTH-column parallel read port.

Verification (IMG_WIDTH=16, 8x8 tiles, pixel value = {row,col})
REQ-029 Stream 128 pixels with tile_ready=1 -> tile_valid for 2 consecutive cycles, tile_col 0 then 1, tile_data[3][5]=={5,3} then {5,11}, and in_ready=0 throughout.
REQ-030 Hold tile_ready=0 for 5 cycles in DRAIN -> tile_data and tile_col stay unchanged; the next tile is emitted only after tile_ready=1.
REQ-031 Apply in_sof at pixel 40 of a band -> the partial band is discarded, tile_row=0, and the first tile appears after 128 pixels counted from the sof pixel.
REQ-032 Assert rst for 1 cycle during DRAIN at tile_col 1 -> tile_valid=0 next cycle, state FILL, and in_ready=1 in the following cycle.
REQ-033 With the macro defined, in_eol at col 9 -> err=1 sticky, and the next pixel is written at col 0 of the next row; without the macro, err stays 0.
